// File: rtl/uart_cmd_responder_if.sv
// Byte-stream and status signals between uart_cmd_responder and its UART/board neighbours.
// The slave modport is the responder's view; the master modport is the surrounding logic's view.
interface uart_cmd_responder_if;
    logic       rxdata_valid_i;
    logic [7:0] rxdata_i;
    logic       txdata_valid_o;
    logic [7:0] txdata_o;
    logic       uart_busy_i;
    logic [7:0] reg_o;
    logic [7:0] err_count_o;
    logic       busy_o;

    modport slave (
        input  rxdata_valid_i,
        input  rxdata_i,
        input  uart_busy_i,
        output txdata_valid_o,
        output txdata_o,
        output reg_o,
        output err_count_o,
        output busy_o
    );

    modport master (
        output rxdata_valid_i,
        output rxdata_i,
        output uart_busy_i,
        input  txdata_valid_o,
        input  txdata_o,
        input  reg_o,
        input  err_count_o,
        input  busy_o
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Parses A5/CMD/ARG/CHK request frames, executes PING/WRITE/READ/NAK,
// and streams a 5A/RCMD/DATA/RCHK response through the uart_tx strobe/busy handshake.
module uart_cmd_responder #(
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    uart_cmd_responder_if.slave   bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_ARG,
        ST_GET_CHK,
        ST_EXEC,
        ST_SEND,
        ST_GAP,
        ST_WAIT
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_idx;
    logic [7:0]    r_cmd;
    logic [7:0]    r_arg;
    logic [7:0]    r_rcmd;
    logic [7:0]    r_data;
    logic [7:0]    r_rchk;
    logic [7:0]    r_txData;
    logic [7:0]    r_reg;
    logic [7:0]    r_errCount;

    logic [7:0]    w_rcmd;
    logic [7:0]    w_data;
    logic [7:0]    w_rsum;
    logic [7:0]    w_rchk;
    logic [7:0]    w_reqSum;
    logic [7:0]    w_nextByte;
    logic [1:0]    w_nextIdx;

    always_comb begin
        w_rcmd = 8'hEE;
        w_data = r_cmd;
        case (r_cmd)
            8'h01: begin w_rcmd = 8'h01; w_data = r_arg; end
            8'h02: begin w_rcmd = 8'h02; w_data = r_arg; end
            8'h03: begin w_rcmd = 8'h03; w_data = r_reg; end
            default: begin w_rcmd = 8'hEE; w_data = r_cmd; end
        endcase
        w_rsum   = w_rcmd + w_data;
        w_rchk   = 8'h00 - w_rsum;
        w_reqSum = r_cmd + r_arg + bus.rxdata_i;
    end

    always_comb begin
        w_nextIdx  = r_idx + 2'd1;
        w_nextByte = 8'h5A;
        case (w_nextIdx)
            2'd1:    w_nextByte = r_rcmd;
            2'd2:    w_nextByte = r_data;
            2'd3:    w_nextByte = r_rchk;
            default: w_nextByte = 8'h5A;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_idx      <= 2'd0;
            r_cmd      <= 8'h00;
            r_arg      <= 8'h00;
            r_rcmd     <= 8'h00;
            r_data     <= 8'h00;
            r_rchk     <= 8'h00;
            r_txData   <= 8'h00;
            r_reg      <= 8'h00;
            r_errCount <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rxdata_valid_i && bus.rxdata_i == 8'hA5) begin
                        r_state <= ST_GET_CMD;
                        r_timer <= '0;
                    end
                end
                ST_GET_CMD, ST_GET_ARG, ST_GET_CHK: begin
                    // A byte in the expiry cycle takes priority over the timeout.
                    if (bus.rxdata_valid_i) begin
                        r_timer <= '0;
                        case (r_state)
                            ST_GET_CMD: begin
                                r_cmd   <= bus.rxdata_i;
                                r_state <= ST_GET_ARG;
                            end
                            ST_GET_ARG: begin
                                r_arg   <= bus.rxdata_i;
                                r_state <= ST_GET_CHK;
                            end
                            default: begin
                                if (w_reqSum == 8'h00) begin
                                    r_state <= ST_EXEC;
                                end else begin
                                    r_state <= ST_IDLE;
                                    if (r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
                                end
                            end
                        endcase
                    end else if (r_timer == TIMER_LAST) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        if (r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (r_cmd == 8'h02) r_reg <= r_arg;
                    r_rcmd   <= w_rcmd;
                    r_data   <= w_data;
                    r_rchk   <= w_rchk;
                    r_idx    <= 2'd0;
                    r_txData <= 8'h5A;
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (!bus.uart_busy_i) r_state <= ST_GAP;
                end
                ST_GAP: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!bus.uart_busy_i) begin
                        if (r_idx != 2'd3) begin
                            r_idx    <= w_nextIdx;
                            r_txData <= w_nextByte;
                            r_state  <= ST_SEND;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The strobe is decoded from the registered state so the first byte leaves two cycles after CHK.
    assign bus.txdata_valid_o = (r_state == ST_SEND) && !bus.uart_busy_i;
    assign bus.txdata_o       = r_txData;
    assign bus.reg_o          = r_reg;
    assign bus.err_count_o    = r_errCount;
    assign bus.busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: a small uart_tx busy model, a strobe monitor,
// and a linear sequence of request frames with hand-computed responses.
module tb_uart_cmd_responder;

    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_cmd_responder_if busIf();

    uart_cmd_responder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (busIf)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass = 0;
    int nFail = 0;

    // uart_tx stand-in: busy for busyLen cycles starting the cycle after each strobe.
    int busyLen = 3;
    int busyLeft = 0;
    always @(posedge clk) begin
        if (reset) busyLeft <= 0;
        else if (busIf.txdata_valid_o) busyLeft <= busyLen;
        else if (busyLeft > 0) busyLeft <= busyLeft - 1;
    end
    assign busIf.uart_busy_i = (busyLeft != 0);

    logic [7:0] txLog[$];
    int nBackToBack = 0;
    int nBusyStrobe = 0;
    logic prevValid = 1'b0;
    always @(negedge clk) begin
        if (busIf.txdata_valid_o === 1'b1) begin
            txLog.push_back(busIf.txdata_o);
            if (prevValid) nBackToBack++;
            if (busIf.uart_busy_i) nBusyStrobe++;
        end
        prevValid = (busIf.txdata_valid_o === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        busIf.rxdata_valid_i = 1'b1;
        busIf.rxdata_i       = b;
        @(posedge clk);
        #1;
        busIf.rxdata_valid_i = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        applyStimulus(b0);
        applyStimulus(b1);
        applyStimulus(b2);
        applyStimulus(b3);
    endtask

    task automatic waitTx(input string tag, input int n, input bit needIdle, input int limit);
        int cyc = 0;
        while (!((txLog.size() >= n) && (!needIdle || busIf.busy_o == 1'b0)) && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_reached"}, 32'((txLog.size() >= n) && (!needIdle || busIf.busy_o == 1'b0)), 32'd1);
    endtask

    function automatic logic [7:0] txAt(input int i);
        if (i < txLog.size()) return txLog[i];
        return 8'hxx;
    endfunction

    task automatic checkResponse(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3);
        checkOutput({tag, "_count"}, 32'(txLog.size()), 32'd4);
        checkOutput({tag, "_b0"}, {24'd0, txAt(0)}, {24'd0, b0});
        checkOutput({tag, "_b1"}, {24'd0, txAt(1)}, {24'd0, b1});
        checkOutput({tag, "_b2"}, {24'd0, txAt(2)}, {24'd0, b2});
        checkOutput({tag, "_b3"}, {24'd0, txAt(3)}, {24'd0, b3});
    endtask

    initial begin
        busIf.rxdata_valid_i = 1'b0;
        busIf.rxdata_i       = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_txvalid", 32'(busIf.txdata_valid_o), 32'd0);
        checkOutput("rst_txdata", 32'(busIf.txdata_o), 32'h00);
        checkOutput("rst_reg", 32'(busIf.reg_o), 32'h00);
        checkOutput("rst_err", 32'(busIf.err_count_o), 32'h00);
        checkOutput("rst_busy", 32'(busIf.busy_o), 32'd0);
        reset = 1'b0;

        // PING 3C
        txLog.delete();
        sendFrame(8'hA5, 8'h01, 8'h3C, 8'hC3);
        waitTx("ping", 4, 1'b1, 500);
        checkResponse("ping", 8'h5A, 8'h01, 8'h3C, 8'hC3);
        checkOutput("ping_reg", 32'(busIf.reg_o), 32'h00);
        checkOutput("ping_err", 32'(busIf.err_count_o), 32'h00);

        // WRITE 05 with cycle-exact latency around the CHK byte
        txLog.delete();
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h05);
        @(posedge clk);
        #1;
        busIf.rxdata_valid_i = 1'b1;
        busIf.rxdata_i       = 8'hF9;
        @(posedge clk);
        #1;
        busIf.rxdata_valid_i = 1'b0;
        checkOutput("wr_n1_busy", 32'(busIf.busy_o), 32'd1);
        checkOutput("wr_n1_reg", 32'(busIf.reg_o), 32'h00);
        checkOutput("wr_n1_txvalid", 32'(busIf.txdata_valid_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("wr_n2_reg", 32'(busIf.reg_o), 32'h05);
        checkOutput("wr_n2_txvalid", 32'(busIf.txdata_valid_o), 32'd1);
        checkOutput("wr_n2_txdata", 32'(busIf.txdata_o), 32'h5A);
        waitTx("write", 4, 1'b1, 500);
        checkResponse("write", 8'h5A, 8'h02, 8'h05, 8'hF9);

        // READ returns the written value
        txLog.delete();
        sendFrame(8'hA5, 8'h03, 8'h00, 8'hFD);
        waitTx("read", 4, 1'b1, 500);
        checkResponse("read", 8'h5A, 8'h03, 8'h05, 8'hF8);

        // Bad checksum: silent drop, error counted
        txLog.delete();
        sendFrame(8'hA5, 8'h01, 8'h3C, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("badchk_count", 32'(txLog.size()), 32'd0);
        checkOutput("badchk_err", 32'(busIf.err_count_o), 32'h01);
        checkOutput("badchk_busy", 32'(busIf.busy_o), 32'd0);

        // Unknown command answers NAK and leaves the register alone
        txLog.delete();
        sendFrame(8'hA5, 8'h7F, 8'h00, 8'h81);
        waitTx("nak", 4, 1'b1, 500);
        checkResponse("nak", 8'h5A, 8'hEE, 8'h7F, 8'h93);
        checkOutput("nak_reg", 32'(busIf.reg_o), 32'h05);

        // Timeout after exactly TIMEOUT idle clocks
        txLog.delete();
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        checkOutput("to_edge_busy", 32'(busIf.busy_o), 32'd1);
        checkOutput("to_edge_err", 32'(busIf.err_count_o), 32'h01);
        @(posedge clk);
        #1;
        checkOutput("to_busy", 32'(busIf.busy_o), 32'd0);
        checkOutput("to_err", 32'(busIf.err_count_o), 32'h02);
        sendFrame(8'hA5, 8'h01, 8'h55, 8'hAA);
        waitTx("ping55", 4, 1'b1, 500);
        checkResponse("ping55", 8'h5A, 8'h01, 8'h55, 8'hAA);

        // Byte landing in the expiry cycle wins over the timeout
        txLog.delete();
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        repeat (TIMEOUT - 2) @(posedge clk);
        applyStimulus(8'h3C);
        applyStimulus(8'hC3);
        waitTx("tie", 4, 1'b1, 500);
        checkResponse("tie", 8'h5A, 8'h01, 8'h3C, 8'hC3);
        checkOutput("tie_err", 32'(busIf.err_count_o), 32'h02);

        // Long transmitter busy, with rx bytes injected mid-response
        busyLen = 1042;
        txLog.delete();
        sendFrame(8'hA5, 8'h02, 8'hAA, 8'h54);
        waitTx("hs_first", 1, 1'b0, 200);
        sendFrame(8'hA5, 8'h01, 8'h3C, 8'hC3);
        waitTx("hs", 4, 1'b1, 6000);
        repeat (20) @(posedge clk);
        #1;
        checkResponse("hs", 8'h5A, 8'h02, 8'hAA, 8'h54);
        checkOutput("hs_busy", 32'(busIf.busy_o), 32'd0);
        checkOutput("hs_reg", 32'(busIf.reg_o), 32'hAA);
        checkOutput("hs_err", 32'(busIf.err_count_o), 32'h02);
        checkOutput("hs_backtoback", 32'(nBackToBack), 32'd0);
        checkOutput("hs_strobe_busy", 32'(nBusyStrobe), 32'd0);
        busyLen = 3;
        repeat (1100) @(posedge clk);

        // Reset after the second strobe aborts the response
        txLog.delete();
        sendFrame(8'hA5, 8'h01, 8'h3C, 8'hC3);
        waitTx("rstmid_two", 2, 1'b0, 200);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstmid_txvalid", 32'(busIf.txdata_valid_o), 32'd0);
        checkOutput("rstmid_txdata", 32'(busIf.txdata_o), 32'h00);
        checkOutput("rstmid_reg", 32'(busIf.reg_o), 32'h00);
        checkOutput("rstmid_err", 32'(busIf.err_count_o), 32'h00);
        checkOutput("rstmid_busy", 32'(busIf.busy_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("rstmid_count", 32'(txLog.size()), 32'd2);
        checkOutput("final_backtoback", 32'(nBackToBack), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder that sits between `uart_rx` and `uart_tx` in `top`. It parses 4-byte request frames from the receiver's byte stream and validates their checksum. It executes one of three register commands and sends a 4-byte response frame through the transmitter's strobe/busy handshake. `reg_o` drives board-level state such as `led_rgb_o`, and `err_count_o` records dropped frames.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 24000: number of idle clocks allowed between bytes of a partial request before it is discarded (2 ms at 12 MHz).

Ports:
- `clk_i`, input, 1 bit: 12 MHz clock. The block uses one clock.
- `reset_i`, input, 1 bit: reset, synchronous and active-high.
- `rxdata_valid_i`, input, 1 bit: one-cycle strobe from `uart_rx`; `rxdata_i` is valid in that cycle.
- `rxdata_i`, input, 8 bits: received byte.
- `txdata_valid_o`, output, 1 bit: one-cycle strobe to `uart_tx` that latches `txdata_o`.
- `txdata_o`, output, 8 bits: byte to transmit; registered and held stable outside strobes.
- `uart_busy_i`, input, 1 bit: `uart_tx` is transmitting.
- `reg_o`, output, 8 bits: user register.
- `err_count_o`, output, 8 bits: saturating count of dropped requests.
- `busy_o`, output, 1 bit: high whenever the state is not IDLE.

## Operation

- Request frame: `0xA5`, CMD, ARG, CHK. CHK must satisfy (CMD + ARG + CHK) mod 256 == 0.
- Response frame: `0x5A`, RCMD, DATA, RCHK, where RCHK = (−(RCMD + DATA)) mod 256.
- Commands:
  - `0x01` PING: RCMD=`0x01`, DATA=ARG.
  - `0x02` WRITE: `reg_o` <= ARG; RCMD=`0x02`, DATA=ARG.
  - `0x03` READ: RCMD=`0x03`, DATA=`reg_o`.
  - Any other CMD (NAK): RCMD=`0xEE`, DATA=CMD; `reg_o` is unchanged.
- States:
  - IDLE: a valid byte equal to `0xA5` moves to GET_CMD. Any other byte is discarded silently and is not an error.
  - GET_CMD, GET_ARG, GET_CHK: each valid byte is stored and the FSM advances. Inside a frame, `0xA5` is ordinary data; there is no resync.
  - GET_CHK with a valid byte: if the checksum is good, go to EXEC. If it is bad, go to IDLE and increment `err_count_o`.
  - EXEC, one cycle: perform the register write if the command is WRITE, latch RCMD/DATA/RCHK, set byte index = 0, go to SEND.
  - SEND: while `uart_busy_i`=0, assert `txdata_valid_o` with `txdata_o` = response[index] and go to GAP. While busy is high, stay in SEND.
  - GAP, one cycle: `uart_busy_i` is ignored, covering the transmitter's busy-rise latency. Go to WAIT.
  - WAIT: when `uart_busy_i`=0, go to SEND if index < 3 (index++), otherwise go to IDLE.
- Receive timeout: an idle counter clears on every accepted byte and on entry to GET_CMD. In GET_*, reaching TIMEOUT_CYCLES clocks without a byte sends the FSM to IDLE and increments `err_count_o`.
- If a byte arrives in the same cycle the timeout expires, the byte wins.
- Bytes arriving in EXEC/SEND/GAP/WAIT are dropped and are not counted (half-duplex).
- No timeout applies in the send states. A stuck `uart_busy_i` stalls the block until reset.
- `err_count_o` saturates at `0xFF`.
- Counter width is $clog2(TIMEOUT_CYCLES+1).

## Timing

- Reset values:
  - state IDLE, `txdata_valid_o`=0, `txdata_o`=`0x00`, `reg_o`=`0x00`, `err_count_o`=`0x00`, `busy_o`=0.
  - Index and timeout counters = 0.
- Reset asserted mid-frame or mid-response aborts immediately. No further strobes are issued.
- Latency, with the CHK byte strobed in cycle N:
  - EXEC in cycle N+1.
  - `reg_o` new value visible in N+2.
  - First `txdata_valid_o` (`0x5A`) in N+2 if `uart_busy_i`=0.
- Minimum spacing between consecutive strobes is 3 cycles (SEND, GAP, WAIT). Busy must be observed low before each strobe.
- `txdata_valid_o` is never high in two consecutive cycles. Exactly 4 strobes are issued per accepted request.
- `busy_o` is high from the cycle after `0xA5` is accepted until the cycle after the last WAIT exits.

## Test plan

1. PING: A5 01 3C C3 → tx bytes 5A 01 3C C3. `reg_o` stays 00 and `err_count_o` stays 00.
2. WRITE then READ:
   - A5 02 05 F9 → 5A 02 05 F9, with `reg_o`=05 in N+2.
   - Then A5 03 00 FD → 5A 03 05 F8.
3. Bad checksum and NAK:
   - A5 01 3C 00 → no strobes, `err_count_o`=01.
   - Then A5 7F 00 81 → 5A EE 7F 93.
4. Timeout: A5 01 followed by TIMEOUT_CYCLES idle clocks → IDLE and `err_count_o`+1. A subsequent valid PING 55 (A5 01 55 AA) answers 5A 01 55 AA.
5. Handshake: model `uart_tx` busy for 1042 cycles, starting the cycle after each strobe. Check that no strobe occurs while busy. Check 4 strobes, single-cycle each, in order. Check that rx bytes injected mid-response are ignored.
6. Reset mid-response: assert `reset_i` after the 2nd strobe → no further strobes, and all outputs at reset values the next cycle.
